// File: rtl/digit_scan_ctrl.sv
// Scan controller for a 3-to-8 decoder: steps A through 0..7 with an ON window and a
// dead-time GAP per digit, presenting the latched data nibble of the selected digit.
module digit_scan_ctrl #(
    parameter int ON_CYCLES  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] data,
    input  logic [7:0]  blank_mask,
    output logic [2:0]  A,
    output logic        STA,
    output logic        STB,
    output logic        STC,
    output logic [3:0]  nibble,
    output logic        frame_done
);

    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_a, w_a_nxt;
    logic [31:0]   r_data, w_data_src;
    logic [7:0]    r_mask, w_mask_src;
    logic          w_latch;
    logic          w_done_nxt;
    logic          r_sta, r_stb, r_stc, r_done;
    logic [3:0]    r_nib, w_nib_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_latch     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_ON;
                    w_a_nxt     = 3'd0;
                    w_cnt_nxt   = '0;
                end
            end
            S_ON: begin
                if (r_cnt == ON_LAST) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_a != 3'd7) begin
                        w_state_nxt = S_ON;
                        w_a_nxt     = r_a + 3'd1;
                    end else begin
                        // Frame boundary: en is only honoured here and in IDLE.
                        w_done_nxt  = 1'b1;
                        w_a_nxt     = 3'd0;
                        w_latch     = en;
                        w_state_nxt = en ? S_ON : S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_a_nxt     = 3'd0;
            end
        endcase
    end

    // Outputs are computed from the next state so they can be registered without lag.
    assign w_data_src = w_latch ? data : r_data;
    assign w_mask_src = w_latch ? blank_mask : r_mask;
    assign w_nib_nxt  = (w_state_nxt == S_ON) ? w_data_src[{w_a_nxt, 2'b00} +: 4] : r_nib;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= 3'd0;
            r_data  <= 32'd0;
            r_mask  <= 8'd0;
            r_sta   <= 1'b0;
            r_stb   <= 1'b0;
            r_stc   <= 1'b1;
            r_nib   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_data  <= w_data_src;
            r_mask  <= w_mask_src;
            r_sta   <= (w_state_nxt == S_ON) & ~w_mask_src[w_a_nxt];
            r_stb   <= (w_state_nxt == S_GAP);
            r_stc   <= (w_state_nxt == S_IDLE);
            r_nib   <= w_nib_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign A          = r_a;
    assign STA        = r_sta;
    assign STB        = r_stb;
    assign STC        = r_stc;
    assign nibble     = r_nib;
    assign frame_done = r_done;

endmodule
